// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter feeding one UART transmitter. Each grant is held for a whole packet;
// a stalled packet lock is dropped after TIMEOUT idle cycles. One cycle of arbitration latency, one idle cycle between packets.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [NREQ-1:0]   REQ_VALID_I,
  input  logic [8*NREQ-1:0] REQ_DATA_I,
  input  logic [NREQ-1:0]   REQ_LAST_I,
  output logic [NREQ-1:0]   REQ_READY_O,
  output logic              TX_VALID_O,
  output logic [7:0]        TX_DATA_O,
  input  logic              TX_READY_I,
  output logic [NREQ-1:0]   GRANT_O,
  output logic              TIMEOUT_O
);
  localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0]     STALL_MAX = 16'(TIMEOUT - 1);
  localparam logic [IW-1:0]   PTR_RST   = IW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [15:0]     r_stall, w_stall_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic            w_found;
  logic [IW-1:0]   w_sel;
  int              w_sum;
  logic            w_gvalid;
  logic            w_glast;
  logic [7:0]      w_gdata;
  logic            w_xfer;

  // Scan starts just after the last granted requester and wraps.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_sum   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      if (!w_found && REQ_VALID_I[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) w_gdata = REQ_DATA_I[8*k +: 8];
    end
  end

  assign w_gvalid = |(REQ_VALID_I & r_grant);
  assign w_glast  = |(REQ_LAST_I & r_grant);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= PTR_RST;
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_stall   <= w_stall_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_stall_nxt   = r_stall;
    w_timeout_nxt = 1'b0;
    w_xfer        = 1'b0;
    TX_VALID_O    = 1'b0;
    TX_DATA_O     = '0;
    REQ_READY_O   = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = XFER;
          w_grant_nxt = NREQ'(1) << w_sel;
          w_ptr_nxt   = w_sel;
          w_stall_nxt = '0;
        end
      end
      XFER: begin
        TX_VALID_O  = w_gvalid;
        TX_DATA_O   = w_gdata;
        REQ_READY_O = TX_READY_I ? r_grant : '0;
        w_xfer      = w_gvalid && TX_READY_I;
        if (w_xfer) begin
          w_stall_nxt = '0;
          if (w_glast) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
          end
        end else if (!w_gvalid) begin
          // Transmitter backpressure with data pending never reaches this branch.
          if (r_stall == STALL_MAX) begin
            w_state_nxt   = IDLE;
            w_grant_nxt   = '0;
            w_stall_nxt   = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_stall_nxt = r_stall + 16'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign GRANT_O   = r_grant;
  assign TIMEOUT_O = r_timeout;

  a_grant_onehot: assert property (@(posedge CLK_I) disable iff (RST_I) $onehot0(r_grant));
  a_idle_no_grant: assert property (@(posedge CLK_I) disable iff (RST_I) (r_state == IDLE) |-> (r_grant == '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences, and random traffic against a reference model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4;
  localparam logic [31:0] D = 32'hD3C2B1A0;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        timeout;
  logic [17:0] dut_outs;

  int n_total = 0;
  int n_pass  = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .REQ_VALID_I (req_valid),
    .REQ_DATA_I  (req_data),
    .REQ_LAST_I  (req_last),
    .REQ_READY_O (req_ready),
    .TX_VALID_O  (tx_valid),
    .TX_DATA_O   (tx_data),
    .TX_READY_I  (tx_ready),
    .GRANT_O     (grant),
    .TIMEOUT_O   (timeout)
  );

  assign dut_outs = {grant, tx_valid, req_ready, tx_data, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        txr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs [12];
  logic [3:0] rr_exp [10];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic t, input logic [3:0] g, input logic tv,
                              input logic [3:0] r, input logic [7:0] td, input logic to);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.txr = t;
    x.exp = {g, tv, r, td, to};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic t);
    req_valid = v; req_last = l; req_data = d; tx_ready = t;
    #1;
  endtask

  // Reference model: index of the granted requester (-1 when idle), last granted index,
  // number of consecutive stalled cycles in the current lock, pending timeout pulse.
  int m_g, m_last, m_stall;
  bit m_to;

  task automatic model_reset();
    m_g = -1; m_last = NREQ - 1; m_stall = 0; m_to = 0;
  endtask

  function automatic logic [17:0] model_outs();
    logic [3:0] g, r;
    logic       v;
    logic [7:0] d;
    g = '0; r = '0; v = 1'b0; d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (k == m_g) begin
        g[k] = 1'b1;
        v    = req_valid[k];
        d    = req_data[8*k +: 8];
      end
    end
    if (tx_ready) r = g;
    return {g, v, r, d, m_to};
  endfunction

  task automatic model_step();
    bit nto, got;
    nto = 0; got = 0;
    if (m_g < 0) begin
      for (int j = 1; j <= NREQ; j++) begin
        if (!got && req_valid[(m_last + j) % NREQ]) begin
          got = 1; m_g = (m_last + j) % NREQ; m_last = m_g; m_stall = 0;
        end
      end
    end else if (req_valid[m_g] && tx_ready) begin
      m_stall = 0;
      if (req_last[m_g]) m_g = -1;
    end else if (!req_valid[m_g]) begin
      if (m_stall + 1 == TIMEOUT) begin
        m_g = -1; nto = 1; m_stall = 0;
      end else begin
        m_stall++;
      end
    end
    m_to = nto;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    #1;
    check("reset_state", dut_outs, 18'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int bad;
    logic [17:0] e;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;

    vecs[0]  = mk(4'b1010, 4'b0000, D,            1, 4'b0000, 0, 4'b0000, 8'h00, 0);
    vecs[1]  = mk(4'b1010, 4'b0010, D,            1, 4'b0010, 1, 4'b0010, 8'hB1, 0);
    vecs[2]  = mk(4'b1010, 4'b0000, D,            1, 4'b0000, 0, 4'b0000, 8'h00, 0);
    vecs[3]  = mk(4'b1010, 4'b1000, D,            0, 4'b1000, 1, 4'b0000, 8'hD3, 0);
    vecs[4]  = mk(4'b1010, 4'b1000, D,            1, 4'b1000, 1, 4'b1000, 8'hD3, 0);
    vecs[5]  = mk(4'b0100, 4'b0000, D,            1, 4'b0000, 0, 4'b0000, 8'h00, 0);
    vecs[6]  = mk(4'b0101, 4'b0000, 32'hD341B1A0, 1, 4'b0100, 1, 4'b0100, 8'h41, 0);
    vecs[7]  = mk(4'b0101, 4'b0000, 32'hD342B1A0, 1, 4'b0100, 1, 4'b0100, 8'h42, 0);
    vecs[8]  = mk(4'b0101, 4'b0100, 32'hD343B1A0, 1, 4'b0100, 1, 4'b0100, 8'h43, 0);
    vecs[9]  = mk(4'b0001, 4'b0000, D,            1, 4'b0000, 0, 4'b0000, 8'h00, 0);
    vecs[10] = mk(4'b0001, 4'b0001, D,            1, 4'b0001, 1, 4'b0001, 8'hA0, 0);
    vecs[11] = mk(4'b0000, 4'b0000, D,            1, 4'b0000, 0, 4'b0000, 8'h00, 0);
    rr_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
               4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Directed vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].txr);
      check($sformatf("vec%0d", i), dut_outs, vecs[i].exp);
      tick();
    end

    // Round robin with all requesters sending one-byte packets
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 4'b1111, D, 1);
      check($sformatf("rr%0d", i), grant, rr_exp[i]);
      tick();
    end

    // Stall timeout after the first non-last byte
    do_reset();
    drive(4'b0001, 4'b0000, D, 1);
    check("to_idle", grant, 4'b0000);
    tick();
    drive(4'b0001, 4'b0000, D, 1);
    check("to_byte1", {tx_valid, req_ready}, 5'b1_0001);
    tick();
    drive(4'b0000, 4'b0000, D, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_hold%0d", i), {grant, timeout}, 5'b0001_0);
      tick();
    end
    check("to_drop", {grant, timeout}, 5'b0000_1);
    tick();
    check("to_pulse_end", {grant, timeout}, 5'b0000_0);

    // Long transmitter backpressure never times out
    do_reset();
    drive(4'b0001, 4'b0001, D, 0);
    tick();
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (grant !== 4'b0001 || timeout !== 1'b0 || req_ready !== 4'b0000 || tx_valid !== 1'b1) bad++;
      tick();
    end
    check("bp_hold_bad_cycles", bad, 0);
    drive(4'b0001, 4'b0001, D, 1);
    check("bp_release", {tx_valid, req_ready, tx_data}, {1'b1, 4'b0001, 8'hA0});
    tick();
    check("bp_done", grant, 4'b0000);

    // Reset asserted during the second byte of a packet
    do_reset();
    drive(4'b0001, 4'b0000, D, 1);
    tick();
    drive(4'b0001, 4'b0000, D, 1);
    tick();
    check("rst_mid_pre", grant, 4'b0001);
    rst = 1'b1;
    #1;
    check("rst_mid", {grant, tx_valid, req_ready, timeout}, 10'h0);
    tick();
    check("rst_hold", {grant, tx_valid, req_ready, timeout}, 10'h0);
    rst = 1'b0;
    drive(4'b1010, 4'b0000, D, 1);
    check("rst_post_idle", grant, 4'b0000);
    tick();
    check("rst_first_grant", grant, 4'b0010);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] v, l;
      for (int k = 0; k < NREQ; k++) begin
        v[k] = ($urandom_range(0, 9) < 6);
        l[k] = ($urandom_range(0, 2) == 0);
      end
      drive(v, l, $urandom, ($urandom_range(0, 3) != 0));
      e = model_outs();
      check($sformatf("rand_cyc%0d", c), dut_outs, e);
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of byte requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT, default 1024, SHALL be the consecutive stalled cycles before a packet lock is dropped, legal range 2..65535.
REQ-003 CLK_I  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_I  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 REQ_VALID_I  input  NREQ  SHALL be per-requester byte valid.
REQ-006 REQ_DATA_I  input  8*NREQ  SHALL be per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 REQ_LAST_I  input  NREQ  SHALL mark the final byte of a requester's packet.
REQ-008 REQ_READY_O  output  NREQ  SHALL be per-requester byte accept.
REQ-009 TX_VALID_O  output  1  SHALL be byte valid toward the UART transmitter.
REQ-010 TX_DATA_O  output  8  SHALL be the byte toward the UART transmitter.
REQ-011 TX_READY_I  input  1  SHALL be transmitter accept.
REQ-012 GRANT_O  output  NREQ  SHALL be the one-hot registered grant, all-zero when idle.
REQ-013 TIMEOUT_O  output  1  SHALL be a one-cycle pulse when a lock is dropped by timeout.

Function
REQ-014 A byte SHALL transfer on a rising edge where TX_VALID_O and TX_READY_I are both 1; requester side transfers identically on REQ_VALID_I[g] and REQ_READY_O[g].
REQ-015 The FSM SHALL have exactly two states: IDLE (GRANT_O=0) and XFER (GRANT_O one-hot at g).
REQ-016 In IDLE, when any REQ_VALID_I bit is 1, the arbiter SHALL register a grant to the first valid requester found scanning from (PTR+1) mod NREQ upward with wrap, entering XFER next cycle (one cycle arbitration latency).
REQ-017 PTR SHALL be a registered index of the last granted requester, updated only when a grant is issued.
REQ-018 In XFER, TX_VALID_O SHALL equal REQ_VALID_I[g], TX_DATA_O SHALL equal REQ_DATA_I[g] combinationally, and REQ_READY_O[g] SHALL equal TX_READY_I; all other REQ_READY_O bits SHALL be 0.
REQ-019 In IDLE, TX_VALID_O and all REQ_READY_O SHALL be 0; TX_DATA_O SHALL be 0.
REQ-020 Grant SHALL be held (packet lock) until a transfer with REQ_LAST_I[g]=1; the FSM SHALL return to IDLE on that edge; no other requester may interleave bytes.
REQ-021 A new grant SHALL NOT be issued in the cycle the FSM returns to IDLE; minimum gap between packets is one idle cycle.
REQ-022 Stall counter (16 bit) SHALL clear on entry to XFER and on every transfer, and increment each XFER cycle with REQ_VALID_I[g]=0.
REQ-023 When the stall counter reaches TIMEOUT-1 and REQ_VALID_I[g] is still 0, the FSM SHALL go to IDLE on that edge and TIMEOUT_O SHALL be 1 the following cycle only.
REQ-024 Cycles with REQ_VALID_I[g]=1 and TX_READY_I=0 SHALL NOT count as stall; transmitter backpressure never times out.
REQ-025 Requesters lowering valid while not granted SHALL be ignored; no request is latched.
REQ-026 A single requester repeatedly valid SHALL be re-granted after each one-cycle IDLE gap if no other requester is valid.

Reset
REQ-027 On RST_I=1, state SHALL be IDLE, GRANT_O=0, PTR=NREQ-1, stall counter=0, TIMEOUT_O=0, asynchronously.
REQ-028 Reset asserted mid-packet SHALL abandon the packet; no byte transfers while RST_I=1; after release first grant goes to lowest-index valid requester.

Verification
REQ-029 Reset release, REQ_VALID_I=4'b1010 -> GRANT_O=4'b0010 one cycle later, then 4'b1000 after requester 1 sends LAST.
REQ-030 Requester 2 sends 3-byte packet 0x41,0x42,0x43 (LAST on 0x43) while requester 0 valid -> TX_DATA_O sequence 0x41,0x42,0x43 uninterrupted, then one IDLE cycle, then GRANT_O=4'b0001.
REQ-031 All four valid continuously with 1-byte packets -> grant order 0,1,2,3,0 each separated by one IDLE cycle.
REQ-032 TIMEOUT=4, granted requester drops valid after first non-LAST byte -> FSM IDLE after 4 stalled cycles, TIMEOUT_O high exactly one cycle.
REQ-033 TX_READY_I held 0 for 5000 cycles with granted valid=1 -> grant held, TIMEOUT_O stays 0, byte transfers when TX_READY_I rises.
REQ-034 RST_I pulsed during byte 2 of a packet -> GRANT_O=0 immediately, REQ_READY_O=0, TX_VALID_O=0 while reset is high.
